adc_capture_sched: RTL and testbench

Command-driven scheduler between the SPI byte slave, the ADC sampling front end and the on-chip sample buffer. Parses 4-byte command frames from the SPI receiver, configures the ADC clock divider and trigger level, arms and sequences one-shot captures into the buffer, and streams captured samples back through the SPI transmitter. Sits in `main` between the SPI slave and the ADC/buffer datapath.

---
 rtl/adc_capture_sched.sv | 158 +++++++++++++++
 tb/tb_adc_capture_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sched.sv
//------------------------------------------------------------------------------
// adc_capture_sched: SPI command parser, ADC trigger/capture sequencer, readout.
// Optional ADC_SCHED_TIMEOUT_EN aborts stalled frames.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adc_capture_sched #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_load,
  output logic [7:0]        tx_data,
  input  logic              adc_valid,
  input  logic [7:0]        adc_data,
  output logic [15:0]       adc_div,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [7:0]        buf_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARGH, P_ARGL} pstate_t;
  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_CAPTURE, C_DONE} cstate_t;
  typedef enum logic [1:0] {TX_ZERO, TX_STATUS, TX_READ} txsel_t;

  pstate_t           pstate, pnext;
  cstate_t           cstate, cnext;
  txsel_t            tx_sel;
  logic [7:0]        cmd, arg_h, level, prev_sample;
  logic [ADDR_W-1:0] n_samples, n_last, wptr;
  logic              done, exec, arm, trigger, write, last, timeout_hit;
  logic [15:0]       arg;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else if (rx_valid) idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = !rx_valid && (pstate != P_SYNC) && (idle_cnt == TW'(TIMEOUT));
`else
  // No watchdog: a partial frame waits indefinitely (expression is constant 0).
  assign timeout_hit = (TIMEOUT < 0);
`endif

  assign arg     = {arg_h, rx_data};
  assign exec    = rx_valid && (pstate == P_ARGL);
  assign busy    = (cstate == C_ARMED) || (cstate == C_CAPTURE);
  assign arm     = exec && (cmd == 8'h03) && !busy;
  assign trigger = adc_valid && (prev_sample < level) && (adc_data >= level);
  assign write   = ((cstate == C_ARMED) && trigger) || ((cstate == C_CAPTURE) && adc_valid);
  // N=0 wraps n_last to all-ones, giving a full 2^ADDR_W capture.
  assign n_last  = n_samples - ADDR_ONE;
  assign last    = (wptr == n_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate <= P_SYNC;
      cstate <= C_IDLE;
    end else begin
      pstate <= pnext;
      cstate <= cnext;
    end
  end

  always_comb begin
    pnext = pstate;
    case (pstate)
      P_SYNC:  if (rx_valid && rx_data == 8'h5A) pnext = P_CMD;
      P_CMD:   if (rx_valid) pnext = P_ARGH;
      P_ARGH:  if (rx_valid) pnext = P_ARGL;
      P_ARGL:  if (rx_valid) pnext = P_SYNC;
      default: pnext = P_SYNC;
    endcase
    if (timeout_hit) pnext = P_SYNC;
  end

  always_comb begin
    cnext = cstate;
    case (cstate)
      C_IDLE, C_DONE:     if (arm) cnext = C_ARMED;
      C_ARMED, C_CAPTURE: if (write) cnext = last ? C_DONE : C_CAPTURE;
      default:            cnext = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd         <= 8'h00;
      arg_h       <= 8'h00;
      adc_div     <= 16'd1;
      level       <= 8'h80;
      n_samples   <= '0;
      wptr        <= '0;
      prev_sample <= 8'h00;
      done        <= 1'b0;
      buf_we      <= 1'b0;
      buf_waddr   <= '0;
      buf_wdata   <= 8'h00;
      buf_raddr   <= '0;
      tx_sel      <= TX_ZERO;
    end else begin
      if (rx_valid && pstate == P_CMD)  cmd   <= rx_data;
      if (rx_valid && pstate == P_ARGH) arg_h <= rx_data;
      if (adc_valid) prev_sample <= adc_data;

      buf_we <= write;
      if (write) begin
        buf_waddr <= wptr;
        buf_wdata <= adc_data;
        wptr      <= wptr + ADDR_ONE;
        if (last) done <= 1'b1;
      end

      if (exec) begin
        if (!busy && cmd == 8'h01) adc_div <= arg;
        if (!busy && cmd == 8'h02) level   <= rx_data;
        if (arm) begin
          n_samples <= arg[ADDR_W-1:0];
          wptr      <= '0;
          done      <= 1'b0;
        end
        case (cmd)
          8'h04:   tx_sel <= TX_READ;
          8'h05:   tx_sel <= TX_STATUS;
          default: tx_sel <= TX_ZERO;
        endcase
        if (cmd == 8'h04) buf_raddr <= '0;
      end else if (tx_load && tx_sel == TX_READ) begin
        buf_raddr <= (buf_raddr == n_last) ? '0 : buf_raddr + ADDR_ONE;
      end
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (tx_sel)
      TX_STATUS: tx_data = {done, busy, 6'b0};
      TX_READ:   tx_data = buf_rdata;
      default:   tx_data = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_sched.sv
//------------------------------------------------------------------------------
// tb_adc_capture_sched: scoreboard bench with buffer RAM model and ADC ramp.
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_capture_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_load = 1'b0;
  logic [7:0]  tx_data;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_data = 8'h00;
  logic [15:0] adc_div;
  logic        buf_we;
  logic [9:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic [9:0]  buf_raddr;
  logic [7:0]  buf_rdata = 8'h00;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic        ramp_en = 1'b0;
  logic [7:0]  ramp_val = 8'h00;
  int          ramp_phase = 0;
  logic [7:0]  mem [0:1023];

  adc_capture_sched #(.ADDR_W(10), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .adc_valid(adc_valid),
    .adc_data(adc_data), .adc_div(adc_div), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    buf_rdata <= mem[buf_raddr];
  end

  // Ramp source: one sample every 4 clocks, restarting at 0 when re-enabled.
  always @(negedge clk) begin
    adc_valid = 1'b0;
    if (!ramp_en) begin
      ramp_val   = 8'h00;
      ramp_phase = 0;
    end else begin
      ramp_phase = ramp_phase + 1;
      if (ramp_phase == 4) begin
        ramp_phase = 0;
        adc_valid  = 1'b1;
        adc_data   = ramp_val;
        ramp_val   = ramp_val + 8'h01;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk); rx_data = c;
    @(negedge clk); rx_data = ah;
    @(negedge clk); rx_data = al;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (adc_div !== 16'd1) begin bad++; $display("FAIL rst_adc_div got=%h exp=0001", adc_div); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    total++; if (buf_we !== 1'b0) begin bad++; $display("FAIL rst_buf_we got=%b exp=0", buf_we); end
    total++; if (buf_waddr !== 10'd0) begin bad++; $display("FAIL rst_waddr got=%h exp=0", buf_waddr); end
    total++; if (buf_raddr !== 10'd0) begin bad++; $display("FAIL rst_raddr got=%h exp=0", buf_raddr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_adc_div();
    send_byte(8'h00);
    send_frame(8'h01, 8'h00, 8'h05);
    total++; if (adc_div !== 16'h0005) begin bad++; $display("FAIL adc_div got=%h exp=0005", adc_div); end
  endtask

  task automatic test_capture();
    int cyc;
    logic [17:0] e;
    send_frame(8'h02, 8'h00, 8'h10);
    send_frame(8'h03, 8'h00, 8'h04);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL armed_busy got=%b exp=1", busy); end
    send_frame(8'h01, 8'h00, 8'h33);
    total++; if (adc_div !== 16'h0005) begin bad++; $display("FAIL busy_div_ignored got=%h exp=0005", adc_div); end
    send_frame(8'h03, 8'h00, 8'h02);
    for (int i = 0; i < 4; i++) exp_wr.push_back({10'(i), 8'(8'h10 + i)});
    ramp_en = 1'b1;
    cyc = 0;
    while (exp_wr.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (buf_we === 1'b1) begin
        e = exp_wr.pop_front();
        total++;
        if ({buf_waddr, buf_wdata} !== e) begin
          bad++; $display("FAIL cap_write got=%h/%h exp=%h/%h", buf_waddr, buf_wdata, e[17:8], e[7:0]);
        end
      end
    end
    total++; if (exp_wr.size() != 0) begin bad++; $display("FAIL cap_timeout pending=%0d exp=0", exp_wr.size()); exp_wr.delete(); end
    cyc = 0;
    repeat (40) begin @(negedge clk); if (buf_we === 1'b1) cyc++; end
    total++; if (cyc != 0) begin bad++; $display("FAIL cap_extra_writes got=%0d exp=0", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cap_done_busy got=%b exp=0", busy); end
    ramp_en = 1'b0;
  endtask

  task automatic test_readout();
    logic [7:0] e;
    send_frame(8'h04, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) exp_rd.push_back(8'(8'h10 + (i % 4)));
    while (exp_rd.size() > 0) begin
      repeat (2) @(negedge clk);
      e = exp_rd.pop_front();
      total++; if (tx_data !== e) begin bad++; $display("FAIL readout got=%h exp=%h", tx_data, e); end
      pulse_load();
    end
  endtask

  task automatic test_status(input logic [7:0] e);
    send_frame(8'h05, 8'h00, 8'h00);
    pulse_load();
    repeat (2) @(negedge clk);
    total++; if (tx_data !== e) begin bad++; $display("FAIL status got=%h exp=%h", tx_data, e); end
  endtask

  task automatic test_timeout();
    logic [15:0] e;
`ifdef ADC_SCHED_TIMEOUT_EN
    e = 16'h0005;
`else
    e = 16'h0009;
`endif
    send_byte(8'h5A);
    send_byte(8'h01);
    repeat (5000) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h09);
    total++; if (adc_div !== e) begin bad++; $display("FAIL timeout_div got=%h exp=%h", adc_div, e); end
  endtask

  task automatic test_rst_capture();
    int cyc;
    logic [17:0] e;
    send_frame(8'h02, 8'h00, 8'h10);
    send_frame(8'h03, 8'h00, 8'h08);
    ramp_en = 1'b1;
    cyc = 0;
    while (buf_we !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    total++; if (buf_we !== 1'b1) begin bad++; $display("FAIL midcap_no_write got=%b exp=1", buf_we); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (buf_waddr !== 10'd0) begin bad++; $display("FAIL midrst_waddr got=%h exp=0", buf_waddr); end
    total++; if (adc_div !== 16'd1) begin bad++; $display("FAIL midrst_div got=%h exp=0001", adc_div); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx got=%h exp=00", tx_data); end
    rst = 1'b0;
    ramp_en = 1'b0;
    test_status(8'h00);
    send_frame(8'h02, 8'h00, 8'h10);
    send_frame(8'h03, 8'h00, 8'h02);
    for (int i = 0; i < 2; i++) exp_wr.push_back({10'(i), 8'(8'h10 + i)});
    ramp_en = 1'b1;
    cyc = 0;
    while (exp_wr.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (buf_we === 1'b1) begin
        e = exp_wr.pop_front();
        total++;
        if ({buf_waddr, buf_wdata} !== e) begin
          bad++; $display("FAIL rearm_write got=%h/%h exp=%h/%h", buf_waddr, buf_wdata, e[17:8], e[7:0]);
        end
      end
    end
    total++; if (exp_wr.size() != 0) begin bad++; $display("FAIL rearm_timeout pending=%0d exp=0", exp_wr.size()); exp_wr.delete(); end
    repeat (4) @(negedge clk);
    ramp_en = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rearm_busy got=%b exp=0", busy); end
    test_status(8'h80);
  endtask

  initial begin
    test_reset();
    test_adc_div();
    test_capture();
    test_readout();
    test_status(8'h80);
    test_timeout();
    test_rst_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
